// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared widths, bit positions and FSM states for the top-K engine
package topk_pkg;
    localparam int META_W      = 88;
    localparam int DATA_W      = 512;
    localparam int VAL_W       = 32;
    localparam int PKT_W       = 601;
    localparam int LAST_BIT    = 512;
    localparam int META_LSB    = 513;
    localparam int SESSION_LSB = 0;
    localparam int SESSION_W   = 16;
    localparam int LANES       = DATA_W / VAL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSERT,
        ST_EMIT
    } state_t;
endpackage

// File: rtl/topk_insert_array.sv
// rtl/topk_insert_array.sv - K sorted slots with single-cycle parallel compare/shift insert
module topk_insert_array
    import topk_pkg::*;
#(
    parameter int K = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               ins_valid,
    input  logic [VAL_W-1:0]   ins_value,
    output logic [VAL_W*K-1:0] values_out
);
    logic [VAL_W-1:0] slot_val [K];
    logic [K-1:0]     slot_vld;
    logic [K-1:0]     hit;
    logic [K-1:0]     prev_hit;

    // Slots stay sorted with a valid prefix, so hit is monotonic: the first
    // hit takes the value and every slot below it shifts down. Equal values
    // do not hit, so a new value lands below existing equals.
    always_comb begin
        hit      = '0;
        prev_hit = '0;
        for (int i = 0; i < K; i++) begin
            hit[i] = !slot_vld[i] || (ins_value > slot_val[i]);
        end
        for (int i = 1; i < K; i++) begin
            prev_hit[i] = hit[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < K; i++) begin
                slot_val[i] <= '0;
            end
            slot_vld <= '0;
        end else if (ins_valid) begin
            if (hit[0]) begin
                slot_val[0] <= ins_value;
                slot_vld[0] <= 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (prev_hit[i]) begin
                    slot_val[i] <= slot_val[i-1];
                    slot_vld[i] <= slot_vld[i-1];
                end else if (hit[i]) begin
                    slot_val[i] <= ins_value;
                    slot_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        values_out = '0;
        for (int i = 0; i < K; i++) begin
            values_out[VAL_W*i +: VAL_W] = slot_vld[i] ? slot_val[i] : '0;
        end
    end
endmodule

// File: rtl/pkt_topk_engine.sv
// rtl/pkt_topk_engine.sv - per-message descending top-K over 32-bit lanes of a 512-bit stream
module pkt_topk_engine
    import topk_pkg::*;
#(
    parameter int K = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PKT_W-1:0]             s_axis_pkt_TDATA,
    input  logic                         s_axis_pkt_TVALID,
    output logic                         s_axis_pkt_TREADY,
    output logic [SESSION_W+VAL_W*K-1:0] m_axis_topk_TDATA,
    output logic                         m_axis_topk_TVALID,
    input  logic                         m_axis_topk_TREADY
);
    localparam int CNT_W = $clog2(LANES);

    state_t              state, state_nx;
    logic [DATA_W-1:0]   lane_sr;
    logic [CNT_W-1:0]    lane_cnt;
    logic                last_q;
    logic                first_beat;
    logic [SESSION_W-1:0] session;
    logic                accept;
    logic                emit_done;
    logic                ins_valid;
    logic [VAL_W*K-1:0]  values;
    logic                meta_unused;

    assign meta_unused = ^s_axis_pkt_TDATA[PKT_W-1:META_LSB+SESSION_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx           = state;
        s_axis_pkt_TREADY  = 1'b0;
        m_axis_topk_TVALID = 1'b0;
        ins_valid          = 1'b0;
        accept             = 1'b0;
        emit_done          = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_pkt_TREADY = !rst;
                if (s_axis_pkt_TVALID && !rst) begin
                    accept   = 1'b1;
                    state_nx = ST_INSERT;
                end
            end
            ST_INSERT: begin
                ins_valid = 1'b1;
                if (lane_cnt == CNT_W'(LANES - 1)) begin
                    state_nx = last_q ? ST_EMIT : ST_IDLE;
                end
            end
            ST_EMIT: begin
                m_axis_topk_TVALID = !rst;
                if (m_axis_topk_TREADY && !rst) begin
                    emit_done = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_sr    <= '0;
            lane_cnt   <= '0;
            last_q     <= 1'b0;
            first_beat <= 1'b1;
            session    <= '0;
        end else begin
            if (accept) begin
                lane_sr    <= s_axis_pkt_TDATA[DATA_W-1:0];
                last_q     <= s_axis_pkt_TDATA[LAST_BIT];
                lane_cnt   <= '0;
                first_beat <= 1'b0;
                if (first_beat) begin
                    session <= s_axis_pkt_TDATA[META_LSB+SESSION_LSB +: SESSION_W];
                end
            end
            if (ins_valid) begin
                lane_sr  <= lane_sr >> VAL_W;
                lane_cnt <= lane_cnt + 1'b1;
            end
            if (emit_done) begin
                first_beat <= 1'b1;
            end
        end
    end

    topk_insert_array #(.K(K)) u_array (
        .clk        (clk),
        .rst        (rst),
        .clear      (emit_done),
        .ins_valid  (ins_valid),
        .ins_value  (lane_sr[VAL_W-1:0]),
        .values_out (values)
    );

    assign m_axis_topk_TDATA = m_axis_topk_TVALID ? {values, session} : '0;
endmodule
